// File: rtl/mul8_stats_pkg.sv
// Shared types for the mul8 error-statistics collector.
// Holds the FSM state enum, default widths and the result record.
package mul8_stats_pkg;

  localparam int P_W_DEF   = 16;
  localparam int CNT_W_DEF = 16;
  localparam int SUM_W_DEF = P_W_DEF + CNT_W_DEF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  typedef struct packed {
    logic [SUM_W_DEF-1:0] sum;
    logic [P_W_DEF-1:0]   max;
    logic [CNT_W_DEF-1:0] cnt;
  } res_t;

endpackage

// File: rtl/mul8_err_stats_if.sv
// Sample and result streams of the error-statistics collector.
// master: sample producer / result consumer; slave: the collector.
interface mul8_err_stats_if
  import mul8_stats_pkg::*;
#(
  parameter int P_W   = P_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int SUM_W = P_W + CNT_W
);

  logic             in_valid;
  logic             in_ready;
  logic [P_W-1:0]   exact;
  logic [P_W-1:0]   approx;
  logic             res_valid;
  logic             res_ready;
  logic [SUM_W-1:0] res_sum_abs_err;
  logic [P_W-1:0]   res_max_err;
  logic [CNT_W-1:0] res_err_cnt;

  modport master (
    output in_valid,
    output exact,
    output approx,
    output res_ready,
    input  in_ready,
    input  res_valid,
    input  res_sum_abs_err,
    input  res_max_err,
    input  res_err_cnt
  );

  modport slave (
    input  in_valid,
    input  exact,
    input  approx,
    input  res_ready,
    output in_ready,
    output res_valid,
    output res_sum_abs_err,
    output res_max_err,
    output res_err_cnt
  );

endinterface

// File: rtl/mul8_absdiff.sv
// Combinational |a-b| (larger minus smaller, never wraps) plus a!=b.
// Ports: a, b operands; d absolute difference; ne mismatch flag.
module mul8_absdiff
  import mul8_stats_pkg::*;
#(
  parameter int P_W = P_W_DEF
) (
  input  logic [P_W-1:0] a,
  input  logic [P_W-1:0] b,
  output logic [P_W-1:0] d,
  output logic           ne
);

  always_comb begin
    d  = '0;
    ne = (a != b);
    if (a >= b) begin
      d = a - b;
    end else begin
      d = b - a;
    end
  end

endmodule

// File: rtl/mul8_err_stats.sv
// Error-statistics collector: over N samples sums/maxes |exact-approx|
// and counts mismatches. Ports: clk, rst, start, num_samples, busy, bus.
module mul8_err_stats
  import mul8_stats_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int P_W   = P_W_DEF,
  parameter int SUM_W = P_W + CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  output logic             busy,
  mul8_err_stats_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             s1_vld_q, s1_vld_d;
  logic [P_W-1:0]   s1_abs_q, s1_abs_d;
  logic             s1_ne_q, s1_ne_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [P_W-1:0]   max_q, max_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [P_W-1:0]   abs_w;
  logic             ne_w;
  logic             accept;

  mul8_absdiff #(.P_W(P_W)) u_absdiff (
    .a  (bus.exact),
    .b  (bus.approx),
    .d  (abs_w),
    .ne (ne_w)
  );

  assign accept = (state_q == RUN) && bus.in_valid;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    s1_vld_d = accept;
    s1_abs_d = s1_abs_q;
    s1_ne_d  = s1_ne_q;
    sum_d    = sum_q;
    max_d    = max_q;
    cnt_d    = cnt_q;

    if (accept) begin
      s1_abs_d = abs_w;
      s1_ne_d  = ne_w;
    end

    // Stage 2: fold the registered stage-1 entry into the window.
    if (s1_vld_q) begin
      sum_d = sum_q + {{(SUM_W-P_W){1'b0}}, s1_abs_q};
      if (s1_abs_q > max_q) begin
        max_d = s1_abs_q;
      end
      cnt_d = cnt_q + CNT_W'(s1_ne_q);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          rem_d = num_samples;
          sum_d = '0;
          max_d = '0;
          cnt_d = '0;
          if (num_samples == '0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (accept) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_abs_q <= '0;
      s1_ne_q  <= 1'b0;
      sum_q    <= '0;
      max_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      s1_vld_q <= s1_vld_d;
      s1_abs_q <= s1_abs_d;
      s1_ne_q  <= s1_ne_d;
      sum_q    <= sum_d;
      max_q    <= max_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy                = (state_q != IDLE);
  assign bus.in_ready        = (state_q == RUN);
  assign bus.res_valid       = (state_q == DONE);
  assign bus.res_sum_abs_err = sum_q;
  assign bus.res_max_err     = max_q;
  assign bus.res_err_cnt     = cnt_q;

endmodule
